// File: rtl/riscv_defines.sv
// Shared IF-stage definitions.
// Halfword offsets, aligner modes, RVC test.
package riscv_defines;

  localparam logic OFFS_ALIGNED    = 1'b0;
  localparam logic OFFS_MISALIGNED = 1'b1;

  typedef enum logic [2:0] {
    M_ERR,
    M_LO_C,
    M_LO_32,
    M_HI_C,
    M_HI_32
  } align_mode_e;

  function automatic logic is_compressed(
    input logic [1:0] op
  );
    return op != 2'b11;
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Generic circular FIFO for fetched words.
// Exposes head and head+1 for the aligner.
module riscv_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [WIDTH-1:0]         o_next,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    w_nptr;
  logic             w_push;
  logic             w_pop;

  assign o_full  = r_count == CW'(DEPTH);
  assign w_push  = i_push & ~o_full & ~i_flush;
  assign w_pop   = i_pop & (r_count != '0) & ~i_flush;
  assign w_nptr  = r_rptr + AW'(1);
  assign o_head  = r_mem[r_rptr];
  assign o_next  = r_mem[w_nptr];
  assign o_count = r_count;

  // Storage write; contents need no reset, count guards reads
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointer and count bookkeeping; flush wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= w_nptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/riscv_prefetch_aligner.sv
// Fetch FIFO plus halfword instruction aligner.
// Emits one 16/32-bit instruction per cycle.
module riscv_prefetch_aligner
  import riscv_defines::*;
#(
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic [31:0]            flush_addr_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            in_rdata_i,
  input  logic [TAG_WIDTH-1:0]   in_rtag_i,
  input  logic                   in_err_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [31:0]            out_instr_o,
  output logic [TAG_WIDTH-1:0]   out_rtag_o,
  output logic [31:0]            out_pc_o,
  output logic                   out_compressed_o,
  output logic                   out_err_o,
  output logic [$clog2(DEPTH):0] occupancy_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 32 + TAG_WIDTH + 1;

  typedef struct packed {
    logic [31:0]          rdata;
    logic [TAG_WIDTH-1:0] rtag;
    logic                 err;
  } entry_t;

  entry_t               w_e0;
  entry_t               w_e1;
  entry_t               w_wr;
  logic [EW-1:0]        w_head;
  logic [EW-1:0]        w_next;
  logic [CW-1:0]        w_count;
  logic                 w_full;
  logic                 w_push;
  logic                 w_fire;
  logic                 w_off;
  logic                 w_lo_c;
  logic                 w_hi_c;
  align_mode_e          w_mode;
  logic                 w_need2;
  logic                 w_pop;
  logic [31:0]          w_instr;
  logic [TAG_WIDTH-1:0] w_tag;
  logic                 w_err;
  logic                 w_comp;
  logic [31:0]          w_npc;
  logic                 w_avail;
  logic                 w_valid;
  logic                 w_unused;
  logic [31:0]          r_pc;

  assign w_wr = '{rdata: in_rdata_i,
                  rtag:  in_rtag_i,
                  err:   in_err_i};

  riscv_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush_i),
    .i_push  (w_push),
    .i_wdata (w_wr),
    .i_pop   (w_fire & w_pop),
    .o_head  (w_head),
    .o_next  (w_next),
    .o_count (w_count),
    .o_full  (w_full)
  );

  assign w_e0     = w_head;
  assign w_e1     = w_next;
  assign w_off    = r_pc[1];
  assign w_lo_c   = is_compressed(w_e0.rdata[1:0]);
  assign w_hi_c   = is_compressed(w_e0.rdata[17:16]);
  assign w_unused = ^{flush_addr_i[0], w_e1.rdata[31:16]};

  // Classify head word at the current halfword offset
  always_comb begin
    w_mode = M_ERR;
    unique case (1'b1)
      w_e0.err:
        w_mode = M_ERR;
      !w_e0.err && w_off == OFFS_ALIGNED && w_lo_c:
        w_mode = M_LO_C;
      !w_e0.err && w_off == OFFS_ALIGNED && !w_lo_c:
        w_mode = M_LO_32;
      !w_e0.err && w_off == OFFS_MISALIGNED && w_hi_c:
        w_mode = M_HI_C;
      default:
        w_mode = M_HI_32;
    endcase
  end

  // Build instruction, pop request and next PC per mode
  always_comb begin
    w_need2 = 1'b0;
    w_pop   = 1'b0;
    w_instr = '0;
    w_tag   = w_e0.rtag;
    w_err   = 1'b0;
    w_comp  = 1'b0;
    w_npc   = r_pc + 32'd4;
    unique case (w_mode)
      M_ERR: begin
        w_err = 1'b1;
        w_pop = 1'b1;
        w_npc = {r_pc[31:2] + 30'd1, 2'b00};
      end
      M_LO_C: begin
        w_instr = {16'h0, w_e0.rdata[15:0]};
        w_comp  = 1'b1;
        w_npc   = r_pc + 32'd2;
      end
      M_LO_32: begin
        w_instr = w_e0.rdata;
        w_pop   = 1'b1;
      end
      M_HI_C: begin
        w_instr = {16'h0, w_e0.rdata[31:16]};
        w_comp  = 1'b1;
        w_pop   = 1'b1;
        w_npc   = r_pc + 32'd2;
      end
      M_HI_32: begin
        w_need2 = 1'b1;
        w_pop   = 1'b1;
        w_tag   = w_e0.rtag | w_e1.rtag;
        w_err   = w_e1.err;
        w_instr = w_e1.err ? 32'h0 :
                  {w_e1.rdata[15:0], w_e0.rdata[31:16]};
      end
      default: ;
    endcase
  end

  assign w_avail = w_need2 ? (w_count >= CW'(2))
                           : (w_count != '0);
  assign w_valid = w_avail & ~flush_i;
  assign w_fire  = w_valid & out_ready_i;
  assign w_push  = in_valid_i & in_ready_o;

  assign in_ready_o       = ~w_full;
  assign occupancy_o      = w_count;
  assign out_valid_o      = w_valid;
  assign out_pc_o         = r_pc;
  assign out_instr_o      = w_valid ? w_instr : '0;
  assign out_rtag_o       = w_valid ? w_tag : '0;
  assign out_err_o        = w_valid & w_err;
  assign out_compressed_o = w_valid & w_comp;

  // PC tracking: flush restarts, consumption advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_pc <= '0;
    else if (flush_i) r_pc <= {flush_addr_i[31:1], 1'b0};
    else if (w_fire)  r_pc <= w_npc;
  end

endmodule

// File: tb/tb_riscv_prefetch_aligner.sv
// Random + directed bench for the aligner.
// Reference model works on a word queue.
module tb_riscv_prefetch_aligner;

  localparam int DEPTH = 4;
  localparam int TW    = 4;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [31:0]   fa;
  logic          iv;
  logic          in_ready;
  logic [31:0]   idat;
  logic [TW-1:0] itag;
  logic          ierr;
  logic          out_valid;
  logic          ordy;
  logic [31:0]   out_instr;
  logic [TW-1:0] out_tag;
  logic [31:0]   out_pc;
  logic          out_comp;
  logic          out_err;
  logic [2:0]    occ;

  riscv_prefetch_aligner #(
    .DEPTH     (DEPTH),
    .TAG_WIDTH (TW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_i          (flush),
    .flush_addr_i     (fa),
    .in_valid_i       (iv),
    .in_ready_o       (in_ready),
    .in_rdata_i       (idat),
    .in_rtag_i        (itag),
    .in_err_i         (ierr),
    .out_valid_o      (out_valid),
    .out_ready_i      (ordy),
    .out_instr_o      (out_instr),
    .out_rtag_o       (out_tag),
    .out_pc_o         (out_pc),
    .out_compressed_o (out_comp),
    .out_err_o        (out_err),
    .occupancy_o      (occ)
  );

  typedef struct {
    logic [31:0]   d;
    logic [TW-1:0] t;
    logic          e;
  } wrd_t;

  wrd_t        mq[$];
  logic [31:0] m_pc;
  int          total;
  int          bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic drive(logic f, logic [31:0] a,
                       logic v, logic [31:0] d,
                       logic [TW-1:0] t, logic e,
                       logic r);
    flush = f; fa = a; iv = v;
    idat = d; itag = t; ierr = e; ordy = r;
  endtask

  task automatic model_out(output logic v,
                           output logic [31:0] ins,
                           output logic [TW-1:0] t,
                           output logic e,
                           output logic c,
                           output logic p,
                           output logic [31:0] np);
    wrd_t        w0;
    logic [15:0] hw;
    v = 0; ins = 0; t = 0; e = 0;
    c = 0; p = 0; np = m_pc + 32'd4;
    if (mq.size() == 0) return;
    w0 = mq[0];
    hw = m_pc[1] ? w0.d[31:16] : w0.d[15:0];
    t  = w0.t;
    if (w0.e) begin
      v = 1; e = 1; p = 1;
      np = (m_pc & ~32'd3) + 32'd4;
    end else if (hw[1:0] != 2'b11) begin
      v = 1; c = 1; ins = {16'h0, hw};
      np = m_pc + 32'd2; p = m_pc[1];
    end else if (!m_pc[1]) begin
      v = 1; p = 1; ins = w0.d;
    end else if (mq.size() >= 2) begin
      v = 1; p = 1;
      t = t | mq[1].t;
      e = mq[1].e;
      ins = e ? 32'h0 : {mq[1].d[15:0], hw};
    end
  endtask

  task automatic step();
    logic        ev, ee, ec, ep;
    logic [31:0] ei, enpc;
    logic [TW-1:0] et;
    bit          fire, push;
    model_out(ev, ei, et, ee, ec, ep, enpc);
    if (flush) ev = 0;
    #1;
    chk("valid", 32'(out_valid), 32'(ev));
    chk("occ", 32'(occ), 32'(mq.size()));
    chk("ready", 32'(in_ready),
        32'(mq.size() < DEPTH));
    chk("pc", out_pc, m_pc);
    if (ev) begin
      chk("instr", out_instr, ei);
      chk("tag", 32'(out_tag), 32'(et));
      chk("err", 32'(out_err), 32'(ee));
      chk("comp", 32'(out_comp), 32'(ec));
    end
    fire = ev && ordy;
    push = iv && (mq.size() < DEPTH) && !flush;
    @(posedge clk);
    if (flush) begin
      mq.delete();
      m_pc = {fa[31:1], 1'b0};
    end else begin
      if (fire) begin
        if (ep) void'(mq.pop_front());
        m_pc = enpc;
      end
      if (push) mq.push_back('{idat, itag, ierr});
    end
    #1;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_ready"}, 32'(in_ready), 1);
    chk({tag, "_occ"}, 32'(occ), 0);
    chk({tag, "_pc"}, out_pc, 0);
    chk({tag, "_instr"}, out_instr, 0);
    chk({tag, "_err"}, 32'(out_err), 0);
    chk({tag, "_comp"}, 32'(out_comp), 0);
    chk({tag, "_tag"}, 32'(out_tag), 0);
  endtask

  initial begin
    logic [31:0] a;
    total = 0;
    bad   = 0;
    m_pc  = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #12;
    chk_reset("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    drive(1, 32'h100, 0, 0, 0, 0, 0); step();
    drive(0, 0, 1, 32'h00A30293, 1, 0, 0); step();
    drive(0, 0, 1, 32'h45014585, 2, 0, 0); step();
    chk("tp1_i0", out_instr, 32'h00A30293);
    drive(0, 0, 0, 0, 0, 0, 1); step();
    chk("tp1_i1", out_instr, 32'h00004585);
    chk("tp1_pc1", out_pc, 32'h104);
    step();
    chk("tp1_i2", out_instr, 32'h00004501);
    chk("tp1_occ", 32'(occ), 1);
    step();
    chk("tp1_empty", 32'(occ), 0);

    drive(1, 32'h203, 0, 0, 0, 0, 1); step();
    drive(0, 0, 1, 32'h02931234, 1, 0, 1); step();
    drive(0, 0, 0, 0, 0, 0, 1); step();
    drive(0, 0, 1, 32'hABCD00A3, 4, 0, 0); step();
    chk("tp2_i", out_instr, 32'h00A30293);
    chk("tp2_pc", out_pc, 32'h202);
    chk("tp2_tag", 32'(out_tag), 5);
    drive(0, 0, 0, 0, 0, 0, 1); step(); step();

    drive(1, 32'h0, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 32'h13 | (i << 8), 0, 0, 0);
      step();
    end
    chk("tp3_full", 32'(in_ready), 0);
    drive(0, 0, 1, 32'h413, 0, 0, 1);
    for (int i = 0; i < 5; i++) step();

    drive(1, 32'h300, 0, 0, 0, 0, 0); step();
    drive(0, 0, 1, 32'h12345678, 3, 1, 0); step();
    chk("tp4_err", 32'(out_err), 1);
    chk("tp4_instr", out_instr, 0);
    drive(0, 0, 0, 0, 0, 0, 1); step();
    chk("tp4_pc", out_pc, 32'h304);

    drive(1, 32'h0, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 32'h33, 0, 0, 0); step();
    end
    drive(1, 32'h4A6, 1, 32'h33, 0, 0, 1); step();
    chk("tp5_occ", 32'(occ), 0);
    chk("tp5_pc", out_pc, 32'h4A6);

    drive(1, 32'hFFFFFFFC, 0, 0, 0, 0, 0); step();
    drive(0, 0, 1, 32'h00000013, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 0, 1); step();
    chk("wrap_pc", out_pc, 32'h0);

    drive(0, 0, 1, 32'h13, 1, 0, 0); step(); step();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk_reset("mid");
    mq.delete();
    m_pc = 0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        a = ($urandom_range(0, 3) == 0)
            ? (32'hFFFFFFF8 | ($urandom & 32'h7))
            : $urandom;
        drive(1, a, $urandom_range(0, 1),
              $urandom, TW'($urandom), 0,
              $urandom_range(0, 1));
      end else begin
        drive(0, 0, $urandom_range(0, 9) < 7,
              $urandom, TW'($urandom),
              $urandom_range(0, 15) == 0,
              $urandom_range(0, 9) < 7);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_prefetch_aligner.md
# riscv_prefetch_aligner

Parametrised fetch FIFO plus instruction aligner between the prefetch buffer and the compressed decoder in the IF stage. It stores fetched 32-bit words, with per-word DIFT tag and fetch-error flag, in a DEPTH-entry queue. It emits one aligned instruction per cycle: a 16-bit instruction, or a 32-bit instruction at either halfword offset, including one spanning two words. It tracks the PC and restarts from any halfword-aligned target on flush.

## Interface
Parameters:
- DEPTH, 4: FIFO entries (words); power of two, >= 2.
- TAG_WIDTH, 4: DIFT tag bits per fetched word; >= 1.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  discard all contents and restart at flush_addr_i
- flush_addr_i  in  32  new PC; bit 0 ignored (treated as 0)
- in_valid_i  in  1  fetched word valid
- in_ready_o  out  1  FIFO can accept a word
- in_rdata_i  in  32  fetched word (word-aligned memory data)
- in_rtag_i  in  TAG_WIDTH  DIFT tag of fetched word
- in_err_i  in  1  fetch failed (PMP/bus error) for this word
- out_valid_o  out  1  aligned instruction available
- out_ready_i  in  1  consumer (ID-side) accepts instruction
- out_instr_o  out  32  instruction; compressed ones zero-extended in [31:16]
- out_rtag_o  out  TAG_WIDTH  bitwise OR of tags of all words contributing
- out_pc_o  out  32  PC of out_instr_o
- out_compressed_o  out  1  out_instr_o[1:0] != 2'b11
- out_err_o  out  1  a contributing word carried in_err_i
- occupancy_o  out  $clog2(DEPTH)+1  words currently stored

## Operation
- Storage: circular buffer. Write pointer, read pointer and count are $clog2(DEPTH) / $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- W0 = head entry, W1 = next entry; pc_q holds the PC, and pc_q[1] is the halfword offset within W0.
- pc_q[1]=0, W0[1:0]!=11: compressed, instr={16'h0,W0[15:0]}; needs count>=1; pc+=2, no pop.
- pc_q[1]=0, W0[1:0]==11: 32-bit, instr=W0; needs count>=1; pc+=4, pop 1.
- pc_q[1]=1, W0[17:16]!=11: compressed, instr={16'h0,W0[31:16]}; needs count>=1; pc+=2, pop 1.
- pc_q[1]=1, W0[17:16]==11: misaligned 32-bit, instr={W1[15:0],W0[31:16]}; needs count>=2; pc+=4, pop 1 (W1 becomes head with pc[1]=1).
- At most one pop per cycle. Consumption happens when out_valid_o & out_ready_i.
- Error: if W0.err, out_valid_o=1 when count>=1, with out_err_o=1, out_instr_o=0, out_compressed_o=0. Consuming it pops 1 and sets pc to the next word boundary.
- If a misaligned 32-bit instruction has W1.err: out_valid_o=1 when count>=2, with out_err_o=1 and out_instr_o=0.
- Push when in_valid_i & in_ready_o. in_ready_o = (count < DEPTH); it does not depend combinationally on out_ready_i. Simultaneous push and pop leaves count unchanged.
- Flush has priority over push and pop: count←0, pointers←0, pc_q←{flush_addr_i[31:1],1'b0}. A word presented in the flush cycle is dropped, and out_valid_o=0 in that cycle.
- pc arithmetic is 32-bit, wrapping modulo 2^32.

## Timing
- Reset values: out_valid_o=0, in_ready_o=1, occupancy_o=0, out_pc_o=0, out_instr_o=0, out_err_o=0, out_compressed_o=0, out_rtag_o=0. An async reset mid-stream discards everything.
- A word pushed in cycle N is visible at the outputs in cycle N+1. Outputs are combinational from registered storage and pc_q; there is no path from in_* to out_*.
- Throughput: one instruction per cycle while data is available. A 32-bit stream at offset 2 sustains 1/cycle with count>=2.
- Full: with count=DEPTH, in_ready_o=0 even if a pop occurs that cycle.
- Empty: out_valid_o=0. A misaligned 32-bit instruction with count=1 stalls (out_valid_o=0) until W1 arrives.
- Flush with a halfword target: the upper half of the first fetched word is served first.

## Structure
- Add to riscv_defines: function is_compressed(logic [1:0]) and localparams OFFS_ALIGNED=1'b0, OFFS_MISALIGNED=1'b1.
- The entry record {rdata, rtag, err} is declared locally, because it is parametrised by TAG_WIDTH.
- Sub-module riscv_fetch_fifo holds generic storage: DEPTH, WIDTH, push/pop/flush, and exposes head and head+1. The aligner logic lives in riscv_prefetch_aligner.

## Test plan
- Flush to 0x100, push 0x00A30293, 0x4501_4585 → 0x00A30293@0x100 (compressed=0), then 0x4585@0x104 and 0x4501@0x106 (compressed=1). Only the last two pops empty the FIFO.
- Flush to 0x202, push 0x0293_xxxx, 0xxxxx_00A3 → after the second push, out_instr_o=0x00A30293@0x202. It stalls with count=1. out_rtag_o = OR of both tags (0x1|0x4=0x5).
- DEPTH=4, out_ready_i=0, push 5 words → in_ready_o=0 after 4, occupancy_o=4, fifth word accepted only after two consumes.
- Push a word with in_err_i=1 at pc 0x300 → out_err_o=1 and out_instr_o=0; consume → pc 0x304.
- Flush asserted together with push and consume at count=3 → next cycle occupancy_o=0, out_valid_o=0, out_pc_o = flush target.
- Assert rst_n low mid-stream with count=2 → all outputs at reset values immediately; in_ready_o=1.
